// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, digit width and limits for the BCD-to-binary converter (no ports)
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
  localparam int BIN_MAX = 4095;
  function automatic logic bcd_bad(input logic [BCD_W-1:0] d);
    return d > DIGIT_MAX;
  endfunction
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc_o = acc_i*10 + digit_i by shift-add; in acc_i, digit_i; out acc_o
module bcd_mac10 import bcd_pkg::*; #(
  parameter int ACC_W = 14
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [BCD_W-1:0] digit_i,
  output logic [ACC_W-1:0] acc_o
);
  assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: 4-digit BCD to binary, one digit per clock; in clk, rst_n, in_valid, thou/hund/tens/ones, out_ready; out in_ready, out_valid, binary, err, ovf
module bcd_to_bin_seq import bcd_pkg::*; #(
  parameter int BIN_W = 12,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       thou,
  input  logic [3:0]       hund,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] binary,
  output logic             err,
  output logic             ovf
);
  state_t state_q, state_d;
  logic [3:0][BCD_W-1:0] dig_q, dig_d;
  logic [1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d, mac;
  logic err_r_q, err_r_d;
  logic [BIN_W-1:0] binary_q, binary_d;
  logic err_q, err_d, ovf_q, ovf_d;
  logic big;
  // digits stored ones..thou so idx 0 selects thousands
  bcd_mac10 #(.ACC_W(ACC_W)) u_mac (.acc_i(acc_q), .digit_i(dig_q[idx_q]), .acc_o(mac));
  assign big = |mac[ACC_W-1:BIN_W];
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    idx_d = idx_q;
    acc_d = acc_q;
    err_r_d = err_r_q;
    binary_d = binary_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      state_d = CONV;
      dig_d = {ones, tens, hund, thou};
      idx_d = '0;
      acc_d = '0;
      err_r_d = bcd_bad(thou) | bcd_bad(hund) | bcd_bad(tens) | bcd_bad(ones);
    end else if (state_q == CONV) begin
      acc_d = mac;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = DONE;
        err_d = err_r_q;
        ovf_d = !err_r_q && big;
        binary_d = err_r_q ? '0 : big ? '1 : mac[BIN_W-1:0];
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dig_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      err_r_q <= 1'b0;
      binary_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      err_r_q <= err_r_d;
      binary_q <= binary_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign binary = binary_q;
  assign err = err_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed vectors with a cycle-level reference model checked every cycle
module tb_bcd_to_bin_seq;
  import bcd_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] thou = '0, hund = '0, tens = '0, ones = '0;
  logic in_ready, out_valid, err, ovf;
  logic [11:0] binary;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_t = 0;
  int m_bin = 0;
  bit m_err = 1'b0;
  bit m_ovf = 1'b0;
  logic [13:0] got[$];
  int acc_log[$];
  int hs_log[$];
  bcd_to_bin_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .thou(thou), .hund(hund), .tens(tens), .ones(ones),
    .out_valid(out_valid), .out_ready(out_ready),
    .binary(binary), .err(err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic bit bad(input logic [3:0] a, b, c, d);
    return a > 9 || b > 9 || c > 9 || d > 9;
  endfunction
  function automatic int value(input logic [3:0] a, b, c, d);
    return int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // reference: result is ready 4 edges after accept, released by an output handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else begin
      if (in_valid && in_ready) acc_log.push_back(cyc);
      if (out_valid && out_ready) begin
        got.push_back({err, ovf, binary});
        hs_log.push_back(cyc);
      end
      if (!m_busy && in_valid) begin
        m_busy <= 1'b1;
        m_t <= cyc;
        m_err <= bad(thou, hund, tens, ones);
        m_ovf <= !bad(thou, hund, tens, ones) && value(thou, hund, tens, ones) > BIN_MAX;
        m_bin <= bad(thou, hund, tens, ones) ? 0 :
                 value(thou, hund, tens, ones) > BIN_MAX ? BIN_MAX : value(thou, hund, tens, ones);
      end else if (m_busy && out_ready && cyc - m_t >= 5) begin
        m_busy <= 1'b0;
      end
    end
  end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    bit v;
    @(negedge clk);
    v = m_busy && (cyc - m_t >= 5);
    chk("in_ready", 16'(in_ready), 16'(!m_busy));
    chk("out_valid", 16'(out_valid), 16'(v));
    if (v) begin
      chk("binary", 16'(binary), 16'(m_bin));
      chk("err", 16'(err), 16'(m_err));
      chk("ovf", 16'(ovf), 16'(m_ovf));
    end
    #1;
  endtask
  task automatic send(input logic [3:0] a, b, c, d);
    int k = 0;
    while (!in_ready && k < 50) begin
      step;
      k++;
    end
    chk("send_timeout", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    thou = a;
    hund = b;
    tens = c;
    ones = d;
    step;
    in_valid = 1'b0;
  endtask
  task automatic wait_n(input int target);
    int k = 0;
    while (got.size() < target && k < 60) begin
      step;
      k++;
    end
    chk("done_timeout", 16'(got.size() >= target), 16'd1);
  endtask
  task automatic run(input string nm, input logic [3:0] a, b, c, d, input logic [13:0] exp);
    int n0 = got.size();
    send(a, b, c, d);
    wait_n(n0 + 1);
    if (got.size() > n0) chk(nm, 16'(got[n0]), 16'(exp));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, a0, h0;
    step;
    step;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_binary", 16'(binary), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    rst_n = 1'b1;
    step;
    out_ready = 1'b1;
    a0 = acc_log.size();
    h0 = hs_log.size();
    run("nominal_1234", 4'd1, 4'd2, 4'd3, 4'd4, {2'b00, 12'd1234});
    if (hs_log.size() > h0 && acc_log.size() > a0)
      chk("nominal_latency", 16'(hs_log[h0] - acc_log[a0]), 16'd5);
    step;
    chk("nominal_in_ready_back", 16'(in_ready), 16'd1);
    run("zero", 4'd0, 4'd0, 4'd0, 4'd0, {2'b00, 12'd0});
    run("max_4095", 4'd4, 4'd0, 4'd9, 4'd5, {2'b00, 12'd4095});
    run("ovf_4096", 4'd4, 4'd0, 4'd9, 4'd6, {2'b01, 12'd4095});
    run("ovf_9999", 4'd9, 4'd9, 4'd9, 4'd9, {2'b01, 12'd4095});
    a0 = acc_log.size();
    h0 = hs_log.size();
    run("err_1A00", 4'd1, 4'ha, 4'd0, 4'd0, {2'b10, 12'd0});
    if (hs_log.size() > h0 && acc_log.size() > a0)
      chk("err_latency", 16'(hs_log[h0] - acc_log[a0]), 16'd5);
    out_ready = 1'b0;
    n0 = got.size();
    send(4'd2, 4'd5, 4'd0, 4'd0);
    in_valid = 1'b1;
    thou = 4'd5;
    hund = 4'd5;
    tens = 4'd5;
    ones = 4'd5;
    step;
    in_valid = 1'b0;
    thou = 4'd9;
    hund = 4'd9;
    tens = 4'd9;
    ones = 4'd9;
    for (int k = 0; k < 20 && !out_valid; k++) step;
    chk("bp_valid", 16'(out_valid), 16'd1);
    for (int k = 0; k < 10; k++) begin
      step;
      chk("bp_hold_binary", 16'(binary), 16'd2500);
      chk("bp_hold_in_ready", 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    wait_n(n0 + 1);
    if (got.size() > n0) chk("bp_result", 16'(got[n0]), 16'd2500);
    for (int k = 0; k < 8; k++) step;
    chk("bp_no_extra", 16'(got.size()), 16'(n0 + 1));
    n0 = got.size();
    send(4'd9, 4'd8, 4'd7, 4'd6);
    step;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_binary", 16'(binary), 16'd0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    step;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step;
    chk("mid_rst_no_output", 16'(got.size()), 16'(n0));
    run("after_rst_42", 4'd0, 4'd0, 4'd4, 4'd2, {2'b00, 12'd42});
    n0 = got.size();
    a0 = acc_log.size();
    send(4'd1, 4'd0, 4'd0, 4'd0);
    send(4'd0, 4'd0, 4'd0, 4'd7);
    send(4'd3, 4'd2, 4'd1, 4'd0);
    wait_n(n0 + 3);
    if (got.size() >= n0 + 3) begin
      chk("b2b_1000", 16'(got[n0]), 16'd1000);
      chk("b2b_0007", 16'(got[n0 + 1]), 16'd7);
      chk("b2b_3210", 16'(got[n0 + 2]), 16'd3210);
    end
    if (acc_log.size() >= a0 + 3) begin
      chk("b2b_spacing_1", 16'(acc_log[a0 + 1] - acc_log[a0]), 16'd6);
      chk("b2b_spacing_2", 16'(acc_log[a0 + 2] - acc_log[a0 + 1]), 16'd6);
    end
    step;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter. It takes four BCD digits (thousands, hundreds, tens, ones) from the time-setting input path and produces the 12-bit binary value used by the clock counters. This is the inverse of the display-side binary-to-BCD path. The conversion is multi-cycle, one digit per clock, using a shift-add ×10 accumulator. Valid/ready handshakes are used on both input and output.

## Interface

Parameters:
- `BIN_W`, 12, binary output width; saturation limit is 2^BIN_W−1 (4095).
- `ACC_W`, 14, accumulator width; must hold 9999.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: digit set is presented.
- `in_ready` out 1: block is idle and can accept a digit set.
- `thou` in 4: thousands BCD digit.
- `hund` in 4: hundreds BCD digit.
- `tens` in 4: tens BCD digit.
- `ones` in 4: ones BCD digit.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `binary` out `BIN_W`: converted value.
- `err` out 1: at least one input digit was greater than 9.
- `ovf` out 1: the BCD value exceeded 4095, so `binary` is saturated.

## Operation

- FSM states are IDLE, CONV, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - latch the four digits into internal registers;
    - clear `acc`;
    - set `idx` = 0;
    - compute `err_r` = (any digit > 9);
    - go to CONV.
- **CONV**
  - Each cycle: `acc <= acc*10 + digit[idx]`.
  - Digit order is `thou`, `hund`, `tens`, `ones`.
  - ×10 is computed as `(acc<<3)+(acc<<1)` at `ACC_W` width. No multiplier.
  - `idx` increments every cycle. After the `ones` step (`idx`=3), go to DONE.
  - Invalid digits are still accumulated, masked to 4 bits. The cycle count is fixed at 4 regardless of data.
- **Result registers**, loaded on the CONV→DONE edge:
  - If `err_r`: `binary` = 0, `err` = 1, `ovf` = 0. Error takes precedence over overflow.
  - Else if the final `acc` > 4095: `binary` = 4095, `ovf` = 1, `err` = 0.
  - Else: `binary` = `acc[BIN_W-1:0]`, `err` = 0, `ovf` = 0.
- **DONE**
  - `out_valid` = 1. `binary`, `err` and `ovf` are held stable.
  - On `out_valid & out_ready`, go to IDLE. `out_valid` drops on the next edge.
- `in_ready` is low in CONV and DONE. `in_valid` is ignored there. Digit inputs are sampled only on the accept edge; later changes have no effect.
- **Reset** (any time, including mid-CONV or in DONE):
  - state = IDLE, `acc` = 0, `idx` = 0;
  - `out_valid` = 0, `binary` = 0, `err` = 0, `ovf` = 0;
  - `in_ready` = 1 once reset is released;
  - any in-flight conversion is discarded, with no partial output.

## Timing

- Accept edge T (`in_valid & in_ready` high at T).
- CONV accumulate edges are T+1, T+2, T+3 and T+4.
- `out_valid` goes high after edge T+4. Latency is 4 cycles from accept to valid.
- The earliest `out_ready` takes effect at edge T+5. `in_ready` is high after T+5.
- The next accept is at T+6 at the earliest. Throughput is one conversion per 6 cycles under continuous handshaking. There is no same-cycle output-to-input bypass.
- `in_ready` and `out_valid` are decoded directly from the state register (Moore), not from inputs.
- If `out_ready` is held low, DONE persists indefinitely and outputs are held.

## Structure

- Shared package `bcd_pkg`:
  - state enum: IDLE, CONV, DONE;
  - `BCD_W` = 4;
  - `DIGIT_MAX` = 9;
  - `BIN_MAX` = 4095.
- Sub-module `bcd_mac10`: combinational `acc_o = acc_i*10 + digit_i` at `ACC_W` width, shift-add only. It is instantiated once in the CONV datapath.
- The top level holds the FSM, the digit registers, `idx`, `acc` and the result registers.

## Test plan

- **Nominal:** digits 1,2,3,4 with `out_ready` held high. `out_valid` goes high 4 cycles after accept with `binary` = 1234, `err` = 0, `ovf` = 0. `in_ready` returns 1 cycle after the output handshake.
- **Bounds:**
  - 0,0,0,0 gives `binary` = 0.
  - 4,0,9,5 gives `binary` = 4095, `ovf` = 0.
  - 4,0,9,6 gives `binary` = 4095, `ovf` = 1.
  - 9,9,9,9 gives `binary` = 4095, `ovf` = 1.
- **Invalid digit:** 1,A,0,0 gives `binary` = 0, `err` = 1, `ovf` = 0. The same 4-cycle latency applies.
- **Backpressure and input stability:**
  - Hold `out_ready` = 0 for 10 cycles after valid: outputs stay stable and `in_ready` stays 0.
  - Pulse `in_valid` with digits 5,5,5,5 during CONV: the pulse is ignored and the first result is unchanged.
  - Change the digit inputs after accept: no effect on the result.
- **Reset mid-operation:**
  - Assert `rst_n` low at T+2 during CONV: `out_valid` = 0, `binary` = 0 asynchronously, and `in_ready` = 1 after release.
  - A following conversion of 0,0,4,2 gives `binary` = 42.
- **Back-to-back:** three conversions (1000, 0007, 3210) with `out_ready` tied high. Each result is correct and in order, with a 6-cycle spacing between accepts.
